// File: rtl/llc_cmd_sequencer.sv
// Command sequencer feeding the last-level cache: in-order FIFO, illegal-code filtering,
// address split into tag/index/byte, and clear/print control pulses.
module llc_cmd_sequencer #(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 32,
    parameter int INDEX     = 14,
    parameter int BYTE      = 6,
    parameter int CLEAR_CYC = 4,
    localparam int TAG_W    = ADDR_W - INDEX - BYTE,
    localparam int CW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_n,
    input  logic [ADDR_W-1:0] in_address,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_n,
    output logic [ADDR_W-1:0] out_address,
    output logic [TAG_W-1:0]  out_tag,
    output logic [INDEX-1:0]  out_index,
    output logic [BYTE-1:0]   out_byte,
    output logic              clear_pulse,
    output logic              print_pulse,
    output logic [15:0]       illegal_cnt,
    output logic [CW:0]       fifo_count
);

    typedef enum logic {RUN, CLEAR} state_t;

    state_t              state;
    logic [3:0]          clr_cnt;
    logic [CW-1:0]       wr_ptr;
    logic [CW-1:0]       rd_ptr;
    logic [ADDR_W+3:0]   mem [DEPTH];

    logic                accept;
    logic                legal;
    logic                push;
    logic                pop;
    logic                load;
    logic [3:0]          head_n;
    logic [ADDR_W-1:0]   head_addr;

    assign in_ready  = (fifo_count < (CW+1)'(DEPTH));
    assign accept    = in_valid & in_ready;
    assign legal     = (in_n <= 4'd6) || (in_n == 4'd8) || (in_n == 4'd9);
    assign push      = accept & legal;
    assign head_n    = mem[rd_ptr][ADDR_W+3:ADDR_W];
    assign head_addr = mem[rd_ptr][ADDR_W-1:0];

    // Any head pop (op, clear or print) waits until the output slot is free so order holds.
    assign pop  = (state == RUN) && (fifo_count != '0) && (!out_valid || out_ready);
    assign load = pop && (head_n <= 4'd6);

    assign out_tag   = out_address[ADDR_W-1:INDEX+BYTE];
    assign out_index = out_address[INDEX+BYTE-1:BYTE];
    assign out_byte  = out_address[BYTE-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_n, in_address};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            clr_cnt     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            out_valid   <= 1'b0;
            clear_pulse <= 1'b0;
            print_pulse <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            clear_pulse <= 1'b0;
            print_pulse <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end

            if (accept && !legal && (illegal_cnt != '1)) begin
                illegal_cnt <= illegal_cnt + 1'b1;
            end

            if (load) begin
                out_n       <= head_n;
                out_address <= head_addr;
                out_valid   <= 1'b1;
            end else if (out_ready) begin
                out_valid   <= 1'b0;
            end

            case (state)
                RUN: begin
                    if (pop && head_n == 4'd9) begin
                        print_pulse <= 1'b1;
                    end
                    if (pop && head_n == 4'd8) begin
                        clear_pulse <= 1'b1;
                        clr_cnt     <= 4'(CLEAR_CYC);
                        state       <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (clr_cnt <= 4'd1) begin
                        state <= RUN;
                    end else begin
                        clr_cnt <= clr_cnt - 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_llc_cmd_sequencer.sv
// Directed bench for llc_cmd_sequencer: table of single-command vectors plus
// hand-built sequences for back-pressure, clear stall, print, and mid-traffic reset.
module tb_llc_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_n;
    logic [31:0] in_address;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_n;
    logic [31:0] out_address;
    logic [11:0] out_tag;
    logic [13:0] out_index;
    logic [5:0]  out_byte;
    logic        clear_pulse;
    logic        print_pulse;
    logic [15:0] illegal_cnt;
    logic [3:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    llc_cmd_sequencer #(
        .DEPTH(8), .ADDR_W(32), .INDEX(14), .BYTE(6), .CLEAR_CYC(4)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_n(in_n), .in_address(in_address),
        .out_valid(out_valid), .out_ready(out_ready), .out_n(out_n), .out_address(out_address),
        .out_tag(out_tag), .out_index(out_index), .out_byte(out_byte),
        .clear_pulse(clear_pulse), .print_pulse(print_pulse),
        .illegal_cnt(illegal_cnt), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  n;
        logic [31:0] addr;
        bit          legal;
        logic [11:0] tag;
        logic [13:0] idx;
        logic [5:0]  byt;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int exp_ill;
        int ov_cycles;
        int max_cnt;
        logic [3:0] seen_n;
        int accepted;
        logic [31:0] sent_q[$];
        int first;
        int pulses;

        vecs[0] = '{4'd0,  32'h1234_5678, 1'b1, 12'h123, 14'h1159, 6'h38};
        vecs[1] = '{4'd3,  32'hFFFF_FFFF, 1'b1, 12'hFFF, 14'h3FFF, 6'h3F};
        vecs[2] = '{4'd6,  32'h0000_0000, 1'b1, 12'h000, 14'h0000, 6'h00};
        vecs[3] = '{4'd7,  32'hDEAD_BEEF, 1'b0, 12'h000, 14'h0000, 6'h00};
        vecs[4] = '{4'd2,  32'hABC0_0040, 1'b1, 12'hABC, 14'h0001, 6'h00};
        vecs[5] = '{4'd15, 32'h0000_0000, 1'b0, 12'h000, 14'h0000, 6'h00};
        vecs[6] = '{4'd5,  32'h0010_003F, 1'b1, 12'h001, 14'h0000, 6'h3F};
        vecs[7] = '{4'd4,  32'h000F_FFC0, 1'b1, 12'h000, 14'h3FFF, 6'h00};
        vecs[8] = '{4'd10, 32'h5555_AAAA, 1'b0, 12'h000, 14'h0000, 6'h00};

        rst = 1'b1; in_valid = 1'b0; in_n = '0; in_address = '0; out_ready = 1'b1;
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_illegal", illegal_cnt, 0);
        check("rst_pulses", {clear_pulse, print_pulse}, 0);
        rst = 1'b0;
        tick();

        // Single-command vectors with out_ready held high
        exp_ill = 0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_n = vecs[i].n; in_address = vecs[i].addr;
            tick();
            in_valid = 1'b0;
            check("vec_acc_valid", out_valid, 0);
            check("vec_acc_count", fifo_count, vecs[i].legal ? 1 : 0);
            if (!vecs[i].legal) exp_ill++;
            check("vec_illegal", illegal_cnt, exp_ill);
            tick();
            if (vecs[i].legal) begin
                check("vec_valid", out_valid, 1);
                check("vec_n", out_n, vecs[i].n);
                check("vec_addr", out_address, vecs[i].addr);
                check("vec_tag", out_tag, vecs[i].tag);
                check("vec_index", out_index, vecs[i].idx);
                check("vec_byte", out_byte, vecs[i].byt);
            end else begin
                check("vec_no_valid", out_valid, 0);
            end
            check("vec_count_drained", fifo_count, 0);
            tick();
            check("vec_valid_drop", out_valid, 0);
        end

        // Illegal codes interleaved with a legal one
        ov_cycles = 0; max_cnt = 0; seen_n = 4'hF;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin
                in_valid = 1'b1;
                in_n = (i == 0) ? 4'd7 : (i == 1) ? 4'd12 : 4'd2;
                in_address = 32'h0000_1000 + i;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (out_valid) begin
                ov_cycles++;
                seen_n = out_n;
            end
        end
        exp_ill += 2;
        check("ill_cnt", illegal_cnt, exp_ill);
        check("ill_ov_cycles", ov_cycles, 1);
        check("ill_seen_n", seen_n, 2);
        check("ill_max_count", max_cnt, 1);

        // Clear stall: n=0, n=8, n=1 with back-pressure
        out_ready = 1'b0;
        in_valid = 1'b1; in_n = 4'd0; in_address = 32'h0000_00A0;
        tick();
        in_n = 4'd8; in_address = 32'h0;
        tick();
        check("clr_first_valid", out_valid, 1);
        check("clr_first_n", out_n, 0);
        in_n = 4'd1; in_address = 32'h0000_00B0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("clr_held_valid", out_valid, 1);
            check("clr_held_addr", out_address, 32'h0000_00A0);
            check("clr_no_pulse_early", clear_pulse, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("clr_pulse", clear_pulse, 1);
        check("clr_pulse_no_valid", out_valid, 0);
        first = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check("clr_pulse_once", clear_pulse, 0);
            if (out_valid && first == 0) begin
                first = c;
                check("clr_next_n", out_n, 1);
                check("clr_next_addr", out_address, 32'h0000_00B0);
            end
        end
        check("clr_stall_len", first, 5);

        // Print
        in_valid = 1'b1; in_n = 4'd9; in_address = 32'h0;
        tick();
        in_valid = 1'b0;
        check("prt_before", print_pulse, 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (print_pulse) pulses++;
            check("prt_no_valid", out_valid, 0);
            if (i == 0) check("prt_at_pop", print_pulse, 1);
        end
        check("prt_pulses", pulses, 1);
        check("prt_count", fifo_count, 0);

        // Back-pressure fill then drain
        out_ready = 1'b0; accepted = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_n = 4'd1; in_address = 32'h0000_0100 + i;
            if (in_ready) begin
                accepted++;
                sent_q.push_back(in_address);
            end
            tick();
        end
        in_valid = 1'b0;
        check("bp_accepted", accepted, 9);
        check("bp_in_ready", in_ready, 0);
        check("bp_count", fifo_count, 8);
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            check("bp_drain_valid", out_valid, 1);
            check("bp_drain_addr", out_address, (sent_q.size() > 0) ? sent_q.pop_front() : 32'hX);
            tick();
        end
        check("bp_drain_done", out_valid, 0);
        check("bp_drain_count", fifo_count, 0);

        // Reset with traffic in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_n = 4'd11; in_address = 32'h0;
        tick();
        for (int i = 0; i < 6; i++) begin
            in_n = 4'd3; in_address = 32'h0000_0200 + i;
            tick();
        end
        in_valid = 1'b0;
        check("rs_pre_valid", out_valid, 1);
        check("rs_pre_count", fifo_count, 5);
        check("rs_pre_illegal", illegal_cnt, exp_ill + 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rs_valid", out_valid, 0);
        check("rs_count", fifo_count, 0);
        check("rs_in_ready", in_ready, 1);
        check("rs_illegal", illegal_cnt, 0);
        out_ready = 1'b1;
        in_valid = 1'b1; in_n = 4'd5; in_address = 32'h0000_0777;
        tick();
        in_valid = 1'b0;
        tick();
        check("rs_after_valid", out_valid, 1);
        check("rs_after_addr", out_address, 32'h0000_0777);
        tick();
        check("rs_after_drop", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
